// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned NREGS    = 1 << AW;
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus, register-file write port and scoreboard query signals.
// slave: the arbiter; master: the writeback sources plus the issue stage.
interface regfile_wb_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned XLEN  = regfile_wb_arbiter_pkg::XLEN,
  parameter int unsigned AW    = regfile_wb_arbiter_pkg::AW
);
  import regfile_wb_arbiter_pkg::*;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*AW-1:0]   req_addr;
  logic [N_REQ*XLEN-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;

  logic                  wb_we;
  logic [AW-1:0]         wb_addr;
  logic [XLEN-1:0]       wb_data;

  logic                  rsv_valid;
  logic [AW-1:0]         rsv_addr;
  logic [AW-1:0]         rs1_addr;
  logic [AW-1:0]         rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  stall;

  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr, rs1_addr, rs2_addr,
    input  req_ready, wb_we, wb_addr, wb_data, rs1_busy, rs2_busy, stall
  );

  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr, rs1_addr, rs2_addr,
    output req_ready, wb_we, wb_addr, wb_data, rs1_busy, rs2_busy, stall
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// One-hot arbiter for the writeback port. Round-robin by default; with
// WB_FIXED_PRIO_EN defined it becomes fixed priority (lowest index wins) and
// carries no pointer state.
module regfile_wb_arbiter_rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  import regfile_wb_arbiter_pkg::*;

`ifdef WB_FIXED_PRIO_EN

  // Grant the lowest-indexed requester.
  always_comb begin
    o_gnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[i] && (o_gnt == '0)) o_gnt[i] = 1'b1;
    end
  end

`else

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_d;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // Search upward from the pointer (wrapping); first requester wins and the
  // pointer moves just past it. Every grant is a transfer since ready == grant.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_ptr_d = r_ptr;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = PW'((32'(r_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        w_ptr_d      = (32'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_d;
  end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port among N_REQ
// sources (one grant per cycle), registers the granted write, and keeps a
// per-register pending-write scoreboard for RAW stalls at issue.
// Define WB_FIXED_PRIO_EN for fixed-priority arbitration instead of round-robin.
module regfile_wb_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned XLEN  = regfile_wb_arbiter_pkg::XLEN,
  parameter int unsigned AW    = regfile_wb_arbiter_pkg::AW
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned NumRegs = 1 << AW;

  logic [N_REQ-1:0]   w_gnt;
  logic               w_any;
  logic [AW-1:0]      w_gnt_addr;
  logic [XLEN-1:0]    w_gnt_data;
  logic               w_gnt_real;

  logic               r_wb_we;
  logic [AW-1:0]      r_wb_addr;
  logic [XLEN-1:0]    r_wb_data;

  logic [NumRegs-1:0] r_busy;
  logic [NumRegs-1:0] w_busy_d;

  regfile_wb_arbiter_rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (bus.req_valid),
    .o_gnt (w_gnt)
  );

  assign bus.req_ready = w_gnt;
  assign w_any         = |w_gnt;
  // x0 writes are accepted but never reach the register file.
  assign w_gnt_real    = w_any && (w_gnt_addr != AW'(REG_ZERO));

  // Select the granted requester's address and data.
  always_comb begin
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_addr = bus.req_addr[i*AW +: AW];
        w_gnt_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Writeback stage: one-cycle registered write; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_we <= w_gnt_real;
      if (w_any) begin
        r_wb_addr <= w_gnt_addr;
        r_wb_data <= w_gnt_data;
      end
    end
  end

  assign bus.wb_we   = r_wb_we;
  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_data = r_wb_data;

  // Scoreboard next state: clear applied first so a same-edge reservation of
  // the same register wins; x0 is never busy.
  always_comb begin
    w_busy_d = r_busy;
    if (w_any)         w_busy_d[w_gnt_addr]   = 1'b0;
    if (bus.rsv_valid) w_busy_d[bus.rsv_addr] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_d;
  end

  assign bus.rs1_busy = r_busy[bus.rs1_addr];
  assign bus.rs2_busy = r_busy[bus.rs2_addr];
  assign bus.stall    = bus.rs1_busy | bus.rs2_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (N_REQ=3, XLEN=32, AW=5).
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N_REQ(3), .XLEN(32), .AW(5)) bus ();

  regfile_wb_arbiter #(
    .N_REQ (3),
    .XLEN  (32),
    .AW    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_ptr;
  bit [31:0]   m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_ad_known;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr      = 0;
    m_busy     = '0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    m_ad_known = 1'b1;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // check the registered write after the rising edge.
  task automatic cycle(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                       input logic rv, input logic [4:0] ra, input logic [4:0] q1,
                       input logic [4:0] q2, output logic [2:0] rdy);
    int          g;
    int          base;
    int          k;
    logic [2:0]  exp_rdy;
    logic [4:0]  ga;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.rsv_valid = rv;
    bus.rsv_addr  = ra;
    bus.rs1_addr  = q1;
    bus.rs2_addr  = q2;
    #1;
`ifdef WB_FIXED_PRIO_EN
    base = 0;
`else
    base = m_ptr;
`endif
    g = -1;
    for (int off = 0; off < 3; off++) begin
      k = (base + off) % 3;
      if (g < 0 && v[k]) g = k;
    end
    exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
    rdy = bus.req_ready;
    chk("ready", bus.req_ready, exp_rdy);
    chk("rs1_busy", bus.rs1_busy, m_busy[q1]);
    chk("rs2_busy", bus.rs2_busy, m_busy[q2]);
    chk("stall", bus.stall, m_busy[q1] | m_busy[q2]);
    @(posedge clk);
    if (g >= 0) begin
      ga         = a[g*5 +: 5];
      m_we       = (ga != 0);
      m_ad_known = (ga != 0);
      m_addr     = ga;
      m_data     = d[g*32 +: 32];
      m_busy[ga] = 1'b0;
      m_ptr      = (g + 1) % 3;
    end else begin
      m_we = 1'b0;
    end
    if (rv && ra != 0) m_busy[ra] = 1'b1;
    #1;
    chk("wb_we", bus.wb_we, m_we);
    if (m_ad_known) begin
      chk("wb_addr", bus.wb_addr, m_addr);
      chk("wb_data", bus.wb_data, m_data);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  rdy;
    logic [14:0] ra3;
    logic [95:0] rd3;
    logic [4:0]  hold_addr;
    logic [31:0] hold_data;
    logic [2:0]  rr_exp;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = '0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;
    model_reset();
    #1;
    chk("rst_wb_we", bus.wb_we, 1'b0);
    chk("rst_wb_addr", bus.wb_addr, 5'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-write with x5 reserved.
    cycle(3'b000, 15'd0, 96'd0, 1'b1, 5'd5, 5'd5, 5'd0, rdy);
    chk("busy5_set", bus.rs1_busy, 1'b1);
    cycle(3'b001, {5'd0, 5'd0, 5'd9}, {64'd0, 32'hCAFE0009}, 1'b0, 5'd0, 5'd5, 5'd0, rdy);
    bus.req_valid = 3'b001;
    bus.req_addr  = {5'd0, 5'd0, 5'd10};
    rst           = 1'b1;
    #1;
    chk("midrst_wb_we", bus.wb_we, 1'b0);
    chk("midrst_wb_addr", bus.wb_addr, 5'd0);
    chk("midrst_wb_data", bus.wb_data, 32'd0);
    for (int r = 0; r < 32; r++) begin
      bus.rs1_addr = 5'(r);
      #1;
      chk("midrst_busy", bus.rs1_busy, 1'b0);
    end
    model_reset();
    @(negedge clk);
    bus.req_valid = '0;
    rst           = 1'b0;

    // Round-robin with all requesters valid; pointer starts at 0 after reset.
    for (int j = 0; j < 6; j++) begin
      rd3 = {$urandom, $urandom, $urandom};
      cycle(3'b111, {5'd12, 5'd11, 5'd10}, rd3, 1'b0, 5'd0, 5'd0, 5'd0, rdy);
`ifdef WB_FIXED_PRIO_EN
      rr_exp = 3'b001;
`else
      rr_exp = 3'b001 << (j % 3);
`endif
      chk("rr_seq", rdy, rr_exp);
    end

    // Single writer.
    cycle(3'b001, {5'd0, 5'd0, 5'd3}, {64'd0, 32'hDEADBEEF}, 1'b0, 5'd0, 5'd0, 5'd0, rdy);
    chk("single_ready", rdy, 3'b001);
    chk("single_we", bus.wb_we, 1'b1);
    chk("single_addr", bus.wb_addr, 5'd3);
    chk("single_data", bus.wb_data, 32'hDEADBEEF);

    // x0 write is accepted but dropped.
    cycle(3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'h1234, 32'd0}, 1'b0, 5'd0, 5'd0, 5'd0, rdy);
    chk("x0_ready", rdy, 3'b010);
    chk("x0_we", bus.wb_we, 1'b0);

    // Scoreboard: reserve x7, stall until its write, re-reserve on that edge.
    cycle(3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 5'd0, rdy);
    chk("sb_stall_set", bus.stall, 1'b1);
    cycle(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd7, 5'd0, rdy);
    chk("sb_stall_hold", bus.stall, 1'b1);
    cycle(3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 64'd0}, 1'b1, 5'd7, 5'd7, 5'd0, rdy);
    chk("sb_set_wins", bus.rs1_busy, 1'b1);
    chk("sb_write_we", bus.wb_we, 1'b1);
    cycle(3'b100, {5'd7, 5'd0, 5'd0}, {32'h78, 64'd0}, 1'b0, 5'd0, 5'd0, 5'd7, rdy);
    chk("sb_cleared", bus.stall, 1'b0);

    // Idle: write port quiet, address/data hold, pointer unchanged.
    hold_addr = m_addr;
    hold_data = m_data;
    for (int j = 0; j < 4; j++) begin
      cycle(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd0, 5'd0, rdy);
    end
    chk("idle_we", bus.wb_we, 1'b0);
    chk("idle_addr", bus.wb_addr, hold_addr);
    chk("idle_data", bus.wb_data, hold_data);
    cycle(3'b111, {5'd21, 5'd20, 5'd19}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0, 5'd0, 5'd0, rdy);

    // Randomized traffic against the model.
    for (int j = 0; j < 300; j++) begin
      for (int i = 0; i < 3; i++) ra3[i*5 +: 5] = 5'($urandom_range(0, 31));
      rd3 = {$urandom, $urandom, $urandom};
      cycle(3'($urandom_range(0, 7)), ra3, rd3, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
